// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode encoding, FSM states and opcode helpers shared by the seq_alu slice
package seq_alu_pkg;
  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_GT   = 3'd7;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic logic op_is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_MOD;
  endfunction
endpackage

// File: rtl/seq_alu_div.sv
// seq_alu_div: restoring radix-2 unsigned divider, one quotient bit per cycle over W cycles
module seq_alu_div #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] rem
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;
  logic          fits;
  // the dividend shifts out of the quotient register into the partial remainder
  assign trial = {rem, quotient[W-1]};
  assign fits  = trial >= {1'b0, dvs};
  // load on start, then one restoring step per cycle; done pulses with the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy     <= 1'b1;
        quotient <= a;
        rem      <= '0;
        dvs      <= b;
        cnt      <= CW'(W);
      end else if (busy) begin
        rem      <= fits ? W'(trial - {1'b0, dvs}) : trial[W-1:0];
        quotient <= {quotient[W-2:0], fits};
        cnt      <= cnt - 1'b1;
        busy     <= cnt != CW'(1);
        done     <= cnt == CW'(1);
      end
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered W-bit ALU with valid/ready handshake and a multi-cycle divider for DIV/MOD
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W   = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [OPW-1:0] select,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W:0]     out,
  output logic           div_zero
);
  state_t       state, nxt;
  logic         en, acc, div_go, b_zero, is_mod, div_busy, div_done;
  logic [2:0]   op;
  logic [W-1:0] quo, rem_w;
  assign op     = 3'(select);
  assign b_zero = b == '0;
  assign acc    = in_valid & in_ready;
  assign div_go = acc & op_is_div(op) & !b_zero;
  function automatic logic [W:0] alu(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = '0;
    case (o)
      OP_PASS: r = {1'b0, x};
      OP_ADD:  r = {1'b0, x} + {1'b0, y};
      OP_SUB:  r = {1'b0, x} - {1'b0, y};
      OP_DIV:  r = {1'b0, {W{1'b1}}};
      OP_MOD:  r = {1'b0, x};
      OP_SHL:  r = {x, 1'b0};
      OP_SHR:  r = {2'b00, x[W-1:1]};
      OP_GT:   r = {{W{1'b0}}, x > y};
      default: r = '0;
    endcase
    return r;
  endfunction
  seq_alu_div #(.W(W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_go),
    .a        (a),
    .b        (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quo),
    .rem      (rem_w)
  );
  // in_ready stays low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en <= 1'b0;
    else en <= 1'b1;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  end
  // next state: DONE with a consumed result behaves like IDLE; a lost divider falls back to IDLE
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE, S_DONE: nxt = acc ? (div_go ? S_DIV : S_DONE) : (state == S_DONE && !out_ready) ? S_DONE : S_IDLE;
      S_DIV:          nxt = div_done ? S_DONE : div_busy ? S_DIV : S_IDLE;
      default:        nxt = S_IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    out_valid = state == S_DONE;
    in_ready  = en && (state == S_IDLE || (state == S_DONE && out_ready));
  end
  // result and flag capture: single-cycle ops on accept, divider result when it finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      div_zero <= 1'b0;
      is_mod   <= 1'b0;
    end else if (acc) begin
      out      <= alu(op, a, b);
      div_zero <= op_is_div(op) & b_zero;
      is_mod   <= op == OP_MOD;
    end else if (state == S_DIV && div_done) begin
      out      <= {1'b0, is_mod ? rem_w : quo};
      div_zero <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed W=4 vectors plus W=8 random sweep, checked against a transaction-level model
module tb_seq_alu;
  import seq_alu_pkg::*;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic iv4 = 0, or4 = 0, ir4, ov4, dz4;
  logic [3:0] a4 = 0, b4 = 0;
  logic [2:0] s4 = 0;
  logic [4:0] o4;
  logic iv8 = 0, or8 = 0, ir8, ov8, dz8;
  logic [7:0] a8 = 0, b8 = 0;
  logic [2:0] s8 = 0;
  logic [8:0] o8;
  int tests = 0, fails = 0, cnt8 = 0;
  int q4[$], q8[$];
  logic h4 = 0, h8 = 0;
  logic [5:0] hv4;
  logic [9:0] hv8;
  seq_alu #(.W(4), .OPW(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .select(s4),
    .out_valid(ov4), .out_ready(or4), .out(o4), .div_zero(dz4)
  );
  seq_alu #(.W(8), .OPW(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .select(s8),
    .out_valid(ov8), .out_ready(or8), .out(o8), .div_zero(dz8)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic int model(input int w, input logic [2:0] op, input int x, input int y);
    int m = (1 << (w + 1)) - 1;
    int r = 0;
    int dz = 0;
    case (op)
      OP_PASS: r = x;
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_DIV:  begin dz = (y == 0) ? 1 : 0; r = (y == 0) ? (1 << w) - 1 : x / y; end
      OP_MOD:  begin dz = (y == 0) ? 1 : 0; r = (y == 0) ? x : x % y; end
      OP_SHL:  r = x * 2;
      OP_SHR:  r = x / 2;
      default: r = (x > y) ? 1 : 0;
    endcase
    return (dz << (w + 1)) | (r & m);
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      q8.delete();
      h4 = 0;
      h8 = 0;
      chk("rst_out4", {ov4, ir4, dz4, o4}, 0);
      chk("rst_out8", {ov8, ir8, dz8, o8}, 0);
    end else begin
      if (h4) chk("hold4", {ov4, dz4, o4}, {1'b1, hv4});
      if (h8) chk("hold8", {ov8, dz8, o8}, {1'b1, hv8});
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("sb4_pending", q4.size(), 1);
        else chk("sb4_out", {dz4, o4}, q4.pop_front());
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) chk("sb8_pending", q8.size(), 1);
        else chk("sb8_out", {dz8, o8}, q8.pop_front());
      end
      h4 = ov4 && !or4;
      hv4 = {dz4, o4};
      h8 = ov8 && !or8;
      hv8 = {dz8, o8};
      if (iv4 && ir4) q4.push_back(model(4, s4, int'(a4), int'(b4)));
      if (iv8 && ir8) begin
        q8.push_back(model(8, s8, int'(a8), int'(b8)));
        cnt8++;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go4(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y);
    iv4 = 1; s4 = s; a4 = x; b4 = y;
    tick();
    iv4 = 0;
  endtask
  task automatic div_run(input string nm, input logic [2:0] s, input logic [3:0] x, input logic [3:0] y, input logic [4:0] e);
    int n = 0;
    logic busy_ok = 1;
    go4(s, x, y);
    while (!ov4 && n < 20) begin
      busy_ok &= !ir4;
      tick();
      n++;
    end
    chk({nm, "_lat"}, n, 5);
    chk({nm, "_ir0"}, busy_ok, 1);
    chk({nm, "_out"}, o4, e);
    chk({nm, "_dz"}, dz4, 0);
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end
  initial begin
    int n;
    logic seen;
    #2 rst_n = 0;
    repeat (2) tick();
    chk("rst_state", {ov4, ir4, dz4, o4}, 0);
    rst_n = 1;
    #0 chk("rst_rel_ir", ir4, 0);
    tick();
    chk("ir_after_rel", ir4, 1);
    or4 = 1;
    go4(OP_ADD, 15, 1);
    chk("add_ov", ov4, 1);
    chk("add_out", o4, 5'b10000);
    go4(OP_SUB, 2, 5);
    chk("sub_ov", ov4, 1);
    chk("sub_out", o4, 5'b11101);
    tick();
    chk("idle_ov", ov4, 0);
    div_run("div", OP_DIV, 13, 4, 3);
    div_run("mod", OP_MOD, 13, 4, 1);
    go4(OP_DIV, 9, 0);
    chk("div0_ov", ov4, 1);
    chk("div0_out", o4, 5'b01111);
    chk("div0_dz", dz4, 1);
    go4(OP_MOD, 9, 0);
    chk("mod0_out", o4, 9);
    chk("mod0_dz", dz4, 1);
    tick();
    or4 = 0;
    go4(OP_SHL, 4'b1001, 0);
    chk("shl_out", o4, 5'b10010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", {ov4, ir4, o4}, {2'b10, 5'b10010});
    end
    or4 = 1; iv4 = 1; s4 = OP_GT; a4 = 7; b4 = 3;
    #1 chk("bp_ir", ir4, 1);
    tick();
    iv4 = 0;
    chk("gt_b2b", {ov4, o4}, {1'b1, 5'd1});
    tick();
    chk("gt_drain", ov4, 0);
    iv4 = 1;
    for (int i = 0; i < 6; i++) begin
      s4 = (i % 2 == 0) ? OP_ADD : OP_SHR; a4 = 4'(i * 3); b4 = 4'(i + 5);
      tick();
      chk("tput_ov", ov4, 1);
    end
    iv4 = 0;
    tick();
    go4(OP_DIV, 13, 4);
    tick();
    rst_n = 0;
    #1 chk("mid_rst", {ov4, ir4, o4}, 0);
    tick();
    rst_n = 1;
    seen = 0;
    repeat (10) begin
      tick();
      seen |= ov4;
    end
    chk("mid_rst_noval", seen, 0);
    chk("q4_empty", q4.size(), 0);
    for (int c = 0; c < 400; c++) begin
      iv8 = $urandom_range(0, 2) != 0;
      s8 = 3'($urandom_range(0, 7));
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      or8 = $urandom_range(0, 3) != 0;
      tick();
    end
    iv8 = 0;
    or8 = 1;
    n = 0;
    while ((ov8 || q8.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    chk("sweep_drain", q8.size(), 0);
    chk("sweep_count", cnt8 > 40, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
